// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared state encodings and default bubble lengths for the hazard/flush controller.
package hazard_pkg;

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] RET_WAIT  = 2'd1;
    localparam logic [1:0] INT_DRAIN = 2'd2;
    localparam logic [1:0] INT_ACK   = 2'd3;

    localparam int unsigned RET_BUBBLES_DEF  = 3;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF        = 3;

    typedef struct packed {
        logic stall_F;
        logic stall_D;
        logic flush_D;
        logic flush_E;
        logic intr_ack;
    } ctrl_t;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Hazard sources from ID/EX and the stall/flush controls returned to the pipeline registers.
interface hazard_flush_ctrl_if;

    logic       rd_en_E;
    logic       wr_en_regf_E;
    logic [1:0] ld_dst_E;
    logic [1:0] RA_D;
    logic [1:0] RB_D;
    logic       uses_ra_D;
    logic       uses_rb_D;
    logic       branch_taken_E;
    logic       is_ret_E;
    logic       intr_req;

    logic       stall_F;
    logic       stall_D;
    logic       flush_D;
    logic       flush_E;
    logic       intr_ack;
    logic       busy;

    // Controller side.
    modport master (
        input  rd_en_E, wr_en_regf_E, ld_dst_E, RA_D, RB_D, uses_ra_D, uses_rb_D,
               branch_taken_E, is_ret_E, intr_req,
        output stall_F, stall_D, flush_D, flush_E, intr_ack, busy
    );

    // Pipeline side.
    modport slave (
        output rd_en_E, wr_en_regf_E, ld_dst_E, RA_D, RB_D, uses_ra_D, uses_rb_D,
               branch_taken_E, is_ret_E, intr_req,
        input  stall_F, stall_D, flush_D, flush_E, intr_ack, busy
    );

endinterface

// File: rtl/hazard_flush_ctrl_bubble_counter.sv
// Loadable down-counter that saturates at zero; times RET bubbles and interrupt drains.
module bubble_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline stall/flush controller: load-use, branch squash, RET bubbles, interrupt drain/ack.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cnt/flush_cnt performance counters.
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RET_BUBBLES  = RET_BUBBLES_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_flush_ctrl_if.master  bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] RET_LD   = CNT_W'(RET_BUBBLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             intr_pend_q, intr_pend_d;
    logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0] cnt_val, cnt_q;
    logic             load_use;
    ctrl_t            ctrl;

    bubble_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_q),
        .zero_o     (cnt_zero)
    );

    assign load_use = bus.rd_en_E && bus.wr_en_regf_E &&
                      ((bus.uses_ra_D && (bus.RA_D == bus.ld_dst_E)) ||
                       (bus.uses_rb_D && (bus.RB_D == bus.ld_dst_E)));

    // The entry cycle in RUN is the first bubble, so the wait state ends as the count reaches zero.
    assign cnt_last = cnt_zero || (cnt_q == CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        ctrl     = '0;
        case (state_q)
            RUN: begin
                if (bus.is_ret_E) begin
                    ctrl.stall_F = 1'b1;
                    ctrl.flush_D = 1'b1;
                    ctrl.flush_E = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_val      = RET_LD;
                    state_d      = (RET_BUBBLES > 1) ? RET_WAIT : RUN;
                end else if (bus.branch_taken_E) begin
                    ctrl.flush_D = 1'b1;
                    ctrl.flush_E = 1'b1;
                end else if (load_use) begin
                    ctrl.stall_F = 1'b1;
                    ctrl.stall_D = 1'b1;
                    ctrl.flush_E = 1'b1;
                end else if (intr_pend_q || bus.intr_req) begin
                    ctrl.stall_F = 1'b1;
                    ctrl.flush_D = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_val      = DRAIN_LD;
                    state_d      = (DRAIN_CYCLES > 1) ? INT_DRAIN : INT_ACK;
                end
            end
            RET_WAIT: begin
                ctrl.stall_F = 1'b1;
                ctrl.flush_D = 1'b1;
                ctrl.flush_E = 1'b1;
                cnt_dec      = 1'b1;
                if (cnt_last) state_d = RUN;
            end
            INT_DRAIN: begin
                ctrl.stall_F = 1'b1;
                ctrl.flush_D = 1'b1;
                ctrl.flush_E = bus.is_ret_E || bus.branch_taken_E;
                cnt_dec      = 1'b1;
                if (cnt_last) state_d = INT_ACK;
            end
            INT_ACK: begin
                ctrl.intr_ack = 1'b1;
                ctrl.flush_D  = 1'b1;
                ctrl.flush_E  = 1'b1;
                state_d       = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        intr_pend_d = intr_pend_q;
        if (state_q == INT_ACK) begin
            intr_pend_d = 1'b0;
        end else if (bus.intr_req) begin
            intr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            intr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            intr_pend_q <= intr_pend_d;
        end
    end

    logic stall_F_g, flush_E_g;

    assign stall_F_g    = ctrl.stall_F && !reset;
    assign flush_E_g    = ctrl.flush_E && !reset;
    assign bus.stall_F  = stall_F_g;
    assign bus.stall_D  = ctrl.stall_D && !reset;
    assign bus.flush_D  = ctrl.flush_D && !reset;
    assign bus.flush_E  = flush_E_g;
    assign bus.intr_ack = ctrl.intr_ack && !reset;
    assign bus.busy     = (state_q != RUN) && !reset;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_F_g && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_E_g && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed scoreboard bench for hazard_flush_ctrl: per-cycle expected control vectors.
module tb_hazard_flush_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_flush_ctrl_if hif ();

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    hazard_flush_ctrl #(
        .RET_BUBBLES  (3),
        .DRAIN_CYCLES (3),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Expected vector bit order: {stall_F, stall_D, flush_D, flush_E, intr_ack, busy}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b110100;
    localparam logic [5:0] BR   = 6'b001100;
    localparam logic [5:0] RETR = 6'b101100;
    localparam logic [5:0] RETW = 6'b101101;
    localparam logic [5:0] DRN0 = 6'b101000;
    localparam logic [5:0] DRN  = 6'b101001;
    localparam logic [5:0] DRNF = 6'b101101;
    localparam logic [5:0] ACK  = 6'b001111;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [1:0] dst, input logic [1:0] ra, input logic [1:0] rb,
                         input logic ura, input logic urb, input logic br,
                         input logic ret, input logic irq);
        reset              = rst;
        hif.rd_en_E        = rd;
        hif.wr_en_regf_E   = wr;
        hif.ld_dst_E       = dst;
        hif.RA_D           = ra;
        hif.RB_D           = rb;
        hif.uses_ra_D      = ura;
        hif.uses_rb_D      = urb;
        hif.branch_taken_E = br;
        hif.is_ret_E       = ret;
        hif.intr_req       = irq;
    endtask

    task automatic cyc(input string nm, input logic [5:0] exp);
        exp_t e;
        e.name = nm;
        e.exp  = exp;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [5:0] exp);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(nm, exp);
    endtask

    // Monitor: every cycle is an output cycle; sample mid-cycle on the falling edge.
    initial begin
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = {hif.stall_F, hif.stall_D, hif.flush_D, hif.flush_E, hif.intr_ack, hif.busy};
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset_held", NONE);
        idle("run_idle", NONE);

        // Load-use hazards
        drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_ra", LU);
        idle("lu_ra_after", NONE);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rb", LU);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_no_wr", NONE);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_no_use", NONE);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_no_match", NONE);

        // Branch squash, and branch winning over load-use
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("branch", BR);
        idle("branch_after", NONE);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("branch_over_lu", BR);

        // RET bubbles with an ignored branch in RET_WAIT
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("ret_entry", RETR);
        idle("ret_wait1", RETW);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ret_wait2_br", RETW);
        idle("ret_done", NONE);

        // Interrupt drain and acknowledge
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("int_entry", DRN0);
        idle("int_drain1", DRN);
        idle("int_drain2", DRN);
        idle("int_ack", ACK);
        idle("int_done", NONE);

        // Interrupt deferred behind RET
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("dret_entry", RETR);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("dret_wait1_irq", RETW);
        idle("dret_wait2", RETW);
        idle("dint_entry", DRN0);
        idle("dint_drain1", DRN);
        idle("dint_drain2", DRN);
        idle("dint_ack", ACK);
        idle("dint_done", NONE);

        // Branch during drain ORs in flush_E
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("bint_entry", DRN0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("bint_drain_br", DRNF);
        idle("bint_drain2", DRN);
        idle("bint_ack", ACK);
        idle("bint_done", NONE);

        // Load-use outranks a new interrupt, which then follows
        drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lint_lu", LU);
        idle("lint_entry", DRN0);
        idle("lint_drain1", DRN);
        idle("lint_drain2", DRN);
        idle("lint_ack", ACK);
        idle("lint_done", NONE);

        // RET outranks branch
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rb_entry", RETR);
        idle("rb_wait1", RETW);
        idle("rb_wait2", RETW);
        idle("rb_done", NONE);

        // Reset during drain aborts without ack
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("rint_entry", DRN0);
        idle("rint_drain1", DRN);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rint_reset1", NONE);
        cyc("rint_reset2", NONE);
        idle("rint_after1", NONE);
        idle("rint_after2", NONE);
        idle("rint_after3", NONE);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_queue: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Producer side of the pipeline flush/stall interface: generates stall_F, stall_D, flush_D and flush_E for the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on taken branches, and inserts multi-cycle bubble sequences for RET/RTI.
- Sequences interrupt entry: drains the pipeline, then acknowledges the request.
- Sits beside the decode stage and takes its inputs from the ID and EX stages.

Parameters:
- RET_BUBBLES, 3, cycles of flush/stall after a RET/RTI reaches EX, until the return PC is valid.
- DRAIN_CYCLES, 3, cycles spent draining in-flight instructions before interrupt acknowledge.
- CNT_W, 3, bubble counter width; must satisfy 2^CNT_W > max(RET_BUBBLES, DRAIN_CYCLES).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en_E  in  1  EX-stage instruction reads data memory (load/pop).
- wr_en_regf_E  in  1  EX-stage instruction writes the register file.
- ld_dst_E  in  2  destination register of the EX-stage instruction.
- RA_D, RB_D  in  2 each  source register fields of the decode-stage instruction.
- uses_ra_D, uses_rb_D  in  1 each  decode-stage instruction reads RA / RB.
- branch_taken_E  in  1  branch/jump resolved taken in EX.
- is_ret_E  in  1  RET or RTI in EX.
- intr_req  in  1  level interrupt request.
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold the IF/ID register.
- flush_D  out  1  clear IF/ID to NOP.
- flush_E  out  1  clear ID/EX to NOP.
- intr_ack  out  1  one-cycle interrupt-entry strobe.
- busy  out  1  FSM not in RUN.

Behaviour:
- FSM states: RUN, RET_WAIT, INT_DRAIN, INT_ACK.
- Registers: state, cnt[CNT_W-1:0], intr_pend.
- Outputs are combinational from state, cnt and current inputs.
- Reset (async, active-high): state=RUN, cnt=0, intr_pend=0. While reset is high, all outputs are 0.
- intr_pend:
  - Set on any cycle with intr_req=1 and state!=INT_ACK.
  - Cleared in INT_ACK.
  - Sets and clears have no other side effects.
- RUN, events evaluated in priority order:
  1. is_ret_E: flush_D=1, flush_E=1, stall_F=1; cnt<=RET_BUBBLES-1; next state RET_WAIT. If RET_BUBBLES==1, next state is RUN.
  2. branch_taken_E: flush_D=1, flush_E=1, stall_F=0, stall_D=0; one cycle; stay in RUN.
  3. Load-use, when rd_en_E && wr_en_regf_E && ((uses_ra_D && RA_D==ld_dst_E) || (uses_rb_D && RB_D==ld_dst_E)): stall_F=1, stall_D=1, flush_E=1, flush_D=0. Lasts exactly one cycle, because the bubble removes the condition.
  4. intr_pend (or intr_req) with none of the above: stall_F=1, flush_D=1; cnt<=DRAIN_CYCLES-1; next state INT_DRAIN.
  5. Otherwise: all outputs 0.
- RET_WAIT:
  - stall_F=1, flush_D=1, flush_E=1; cnt decrements.
  - When cnt==0, next state is RUN.
  - branch_taken_E and load-use inputs are ignored (they can only come from squashed slots).
- INT_DRAIN:
  - stall_F=1, flush_D=1, flush_E=0, so older instructions complete.
  - cnt decrements; when cnt==0, next state is INT_ACK.
  - If is_ret_E or branch_taken_E arrives during the drain, the corresponding flush is also asserted (OR into the outputs) and the drain continues.
- INT_ACK: intr_ack=1, stall_F=0, flush_D=1, flush_E=1 for one cycle; intr_pend cleared; next state RUN.
- busy=1 whenever state!=RUN.
- Counter never wraps: it is loaded only on state entry and is not decremented below 0.
- Reset asserted mid-sequence aborts immediately to RUN with no ack.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each cycle with stall_F=1.
  - flush_cnt increments on each cycle with flush_E=1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: state encoding constants (RUN=2'd0, RET_WAIT=2'd1, INT_DRAIN=2'd2, INT_ACK=2'd3) and default values for the bubble-length parameters.
- One sub-module, bubble_counter: loadable CNT_W-bit down-counter with load, dec and zero outputs. Used for both RET_WAIT and INT_DRAIN.

Test Plan:
- Load-use: rd_en_E=1, wr_en_regf_E=1, ld_dst_E=2, RA_D=2, uses_ra_D=1 -> exactly one cycle of stall_F=1, stall_D=1, flush_E=1, flush_D=0; busy stays 0.
- Branch: branch_taken_E=1 for one cycle -> flush_D=1, flush_E=1, stall_F=0 in that cycle only. Branch and load-use in the same cycle -> branch response only.
- RET: is_ret_E=1, RET_BUBBLES=3 -> stall_F/flush_D/flush_E high for 3 consecutive cycles, busy high for 2, then all 0. A branch_taken_E pulse during RET_WAIT changes nothing.
- Interrupt: intr_req pulsed for one cycle in RUN, DRAIN_CYCLES=3 -> 3 cycles of stall_F=1, flush_D=1, flush_E=0, then intr_ack=1 for exactly one cycle, then RUN.
- Deferred interrupt: intr_req pulses during RET_WAIT -> after RET_WAIT, INT_DRAIN starts on the first RUN cycle; the ack follows. Reset asserted in INT_DRAIN -> all outputs 0 at once, intr_ack is never asserted, and busy=0 after reset.
